// File: rtl/sd_arb_pkg.sv
// Shared types and defaults for the SD-card SPI register-port arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_HOLD   = 2'd3
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_HW  = 1'b1;

  localparam int ADR_W_DEF   = 6;
  localparam int DAT_W_DEF   = 18;
  localparam int TIMEOUT_DEF = 1023;

  // Counter must hold TIMEOUT-1; clamp to one bit for the smallest legal TIMEOUT.
  function automatic int tmr_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  localparam int TMR_W_DEF = tmr_width(TIMEOUT_DEF);

endpackage

// File: rtl/sd_arb_timeout.sv
// Clear/enable watchdog counter with a terminal-count flag; saturates at TERMINAL.
module sd_arb_timeout #(
  parameter int           W        = 10,
  parameter logic [W-1:0] TERMINAL = '1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TERMINAL)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/sd_bus_arbiter.sv
// Two-port round-robin arbiter with bus lock and ack watchdog in front of the
// SD-card SPI master register port. Port 0 is the CPU, port 1 a hardware requester.
module sd_bus_arbiter
  import sd_arb_pkg::*;
#(
  parameter int ADR_W   = ADR_W_DEF,
  parameter int DAT_W   = DAT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_peri,
  input  logic             reset,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic             m0_lock,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack,
  output logic             m0_err,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic             m1_lock,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack,
  output logic             m1_err,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack,
  output logic             owner,
  output logic             busy
);

  localparam int             TMR_W    = tmr_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             s_stb_q, s_stb_d;
  logic             s_we_q, s_we_d;
  logic [ADR_W-1:0] s_adr_q, s_adr_d;
  logic [DAT_W-1:0] s_dat_q, s_dat_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             busy_q, busy_d;
  logic             m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic             m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DAT_W-1:0] m0_dat_q, m0_dat_d, m1_dat_q, m1_dat_d;

  logic grant;
  logic win;
  logic own_stb;
  logic own_lock;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;

  assign own_stb  = owner_q ? m1_stb  : m0_stb;
  assign own_lock = owner_q ? m1_lock : m0_lock;

  sd_arb_timeout #(
    .W        (TMR_W),
    .TERMINAL (TMR_LAST)
  ) u_timeout (
    .clk_i (clk_peri),
    .rst_i (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    s_stb_d      = s_stb_q;
    s_we_d       = s_we_q;
    s_adr_d      = s_adr_q;
    s_dat_d      = s_dat_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_dat_d     = m0_dat_q;
    m1_dat_d     = m1_dat_q;
    grant        = 1'b0;
    win          = owner_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_stb || m1_stb) begin
          grant = 1'b1;
          win   = (m0_stb && m1_stb) ? ~last_owner_q : m1_stb;
        end
      end
      ST_ACCESS: begin
        tmr_en = 1'b1;
        // A late ack in the terminal cycle still completes the transfer.
        if (s_ack) begin
          s_stb_d = 1'b0;
          state_d = ST_RESP;
          if (owner_q) begin
            m1_ack_d = 1'b1;
            m1_dat_d = s_we_q ? '0 : s_dat_i;
          end else begin
            m0_ack_d = 1'b1;
            m0_dat_d = s_we_q ? '0 : s_dat_i;
          end
        end else if (tmr_tc) begin
          s_stb_d = 1'b0;
          state_d = ST_IDLE;
          if (owner_q) begin
            m1_err_d = 1'b1;
            m1_dat_d = '0;
          end else begin
            m0_err_d = 1'b1;
            m0_dat_d = '0;
          end
        end
      end
      ST_RESP: begin
        state_d = own_lock ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (own_stb) begin
          grant = 1'b1;
        end else if (!own_lock) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d      = ST_ACCESS;
      s_stb_d      = 1'b1;
      s_we_d       = win ? m1_we    : m0_we;
      s_adr_d      = win ? m1_adr   : m0_adr;
      s_dat_d      = win ? m1_dat_i : m0_dat_i;
      owner_d      = win;
      last_owner_d = win;
      tmr_clr      = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_peri or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_stb_q      <= 1'b0;
      s_we_q       <= 1'b0;
      s_adr_q      <= '0;
      s_dat_q      <= '0;
      owner_q      <= OWNER_CPU;
      last_owner_q <= OWNER_HW;
      busy_q       <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_dat_q     <= '0;
      m1_dat_q     <= '0;
    end else begin
      state_q      <= state_d;
      s_stb_q      <= s_stb_d;
      s_we_q       <= s_we_d;
      s_adr_q      <= s_adr_d;
      s_dat_q      <= s_dat_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      busy_q       <= busy_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_dat_q     <= m0_dat_d;
      m1_dat_q     <= m1_dat_d;
    end
  end

  assign s_stb    = s_stb_q;
  assign s_we     = s_we_q;
  assign s_adr    = s_adr_q;
  assign s_dat_o  = s_dat_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign m0_dat_o = m0_dat_q;
  assign m1_dat_o = m1_dat_q;

endmodule

// File: doc/sd_bus_arbiter.md
Name: sd_bus_arbiter

Overview:
- Two-port arbiter that shares the SD-card SPI master register interface between requesters.
- Port 0 is the SpartanMC CPU path, after the peripheral select decode. Port 1 is a hardware requester, e.g. a logger block-writer.
- Provides round-robin grant, a bus lock for multi-register sequences such as full 512-byte block transfers, and an ack timeout watchdog.
- Sits between the requesters and the SPI master's strobe/we/ack register port.

Parameters:
- ADR_W, 6, register address width of the SPI master.
- DAT_W, 18, data width (SpartanMC word).
- TIMEOUT, 1023, cycles in ACCESS without s_ack before the transaction is aborted with an error; minimum 2.

Ports:
- clk_peri  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_stb  in  1  port 0 request; held high until m0_ack or m0_err.
- m0_we  in  1  port 0 write enable.
- m0_adr  in  ADR_W  port 0 register address.
- m0_dat_i  in  DAT_W  port 0 write data.
- m0_lock  in  1  port 0 requests the grant be kept after the current transaction.
- m0_dat_o  out  DAT_W  read data to port 0.
- m0_ack  out  1  one-cycle completion pulse to port 0.
- m0_err  out  1  one-cycle timeout pulse to port 0.
- m1_stb, m1_we, m1_adr, m1_dat_i, m1_lock, m1_dat_o, m1_ack, m1_err: same as port 0, for port 1.
- s_stb  out  1  strobe to the SPI master.
- s_we  out  1  write enable to the SPI master.
- s_adr  out  ADR_W  address to the SPI master.
- s_dat_o  out  DAT_W  write data to the SPI master.
- s_dat_i  in  DAT_W  read data from the SPI master.
- s_ack  in  1  SPI master acknowledge.
- owner  out  1  current or last grant holder.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- On reset: state=IDLE, every output 0, last_owner=1 (so port 0 wins the first tie), timer=0.
- Reset mid-transaction drops s_stb and discards the transaction; no ack or err is issued.
- States: IDLE, ACCESS, RESP, HOLD.
- IDLE:
  - Only m0_stb high: grant port 0. Only m1_stb high: grant port 1.
  - Both high: grant the port that is not last_owner.
  - On grant: latch we/adr/dat_i of the winner into s_we/s_adr/s_dat_o, set s_stb=1, owner and last_owner = winner, timer=0, go to ACCESS.
  - Arbitration latency: s_stb is high 1 cycle after the requester's stb is sampled.
- ACCESS:
  - s_stb held high; s_we/s_adr/s_dat_o stable.
  - Timer increments each cycle.
  - s_ack sampled high: s_stb<=0, mX_dat_o<=s_dat_i (mX_dat_o<=0 for writes), mX_ack<=1, go to RESP.
  - timer reaches TIMEOUT-1 without s_ack: s_stb<=0, mX_dat_o<=0, mX_err<=1, clear lock, go to IDLE (abort force-releases any lock).
  - s_ack and the timeout in the same cycle: ack wins.
- RESP:
  - mX_ack high for exactly this cycle. The owner's stb is ignored this cycle, since the requester drops it on seeing ack.
  - Next state: HOLD if mX_lock is sampled high this cycle, else IDLE.
- HOLD:
  - Owner retains the grant; the other port's stb is ignored and that port waits.
  - Owner's stb high: latch request, go to ACCESS, no arbitration.
  - Owner's lock low (stb low): go to IDLE. Stb high with lock low is still served; release follows its RESP.
  - Owner's stb and lock both high: served.
- Non-owner outputs: mX_ack, mX_err and mX_dat_o hold 0, except mX_dat_o keeps its last value until that port's next response.
- A requester that drops stb while in ACCESS does not cancel the transaction; ack is still delivered.
- s_stb is low for at least 1 cycle between consecutive transactions, which guarantees the slave sees distinct strobes.

Decomposition:
- sd_arb_pkg:
  - state encoding for IDLE/ACCESS/RESP/HOLD (2 bits).
  - OWNER_CPU=0, OWNER_HW=1.
  - ADR_W/DAT_W defaults.
  - TIMEOUT counter width, clog2(TIMEOUT).
- One sub-module, sd_arb_timeout: a clear/enable counter with a terminal-count flag, reused later for the SD command-response watchdog.
- Grant/mux logic stays in the top level.

Test Plan:
- Single read: m0 stb, adr=6'h02, we=0; slave acks 3 cycles after s_stb with s_dat_i=18'h1A5 -> s_adr=02 one cycle after the request; m0_ack is 1 cycle long with m0_dat_o=18'h1A5; state returns to IDLE; owner=0.
- Simultaneous requests from reset: m0 and m1 both stb -> port 0 served first, then port 1. Then repeat with both stb after last_owner=1 -> port 0 served; the grant order alternates 0,1,0,1.
- Lock sequence: m1 asserts lock and issues 4 writes (adr 6'h10, data 0..3) while m0_stb stays high -> all 4 writes reach the slave consecutively; m0 is granted only after m1_lock drops; m0 sees no ack meanwhile.
- Timeout: TIMEOUT=16, slave never acks -> s_stb falls after 16 cycles; m0_err pulses 1 cycle; m0_dat_o=0; the active lock is cleared and m1 is granted on the next request.
- Ack at the timeout boundary: s_ack arrives in cycle TIMEOUT-1 -> m0_ack=1 and m0_err=0.
- Async reset asserted mid-ACCESS -> s_stb and busy are 0 immediately; no ack or err; after release, the first tie is granted to port 0.
